// File: rtl/matmul_pkg.sv
// Shared sizing, state type and helpers for the matmul sequencer.
// Optional feature macro: MATMUL_BIAS_EN (adds the BIAS preload state).
package matmul_pkg;
   localparam int DATA_WIDTH  = 16;
   localparam int BUS_WIDTH   = 32;
   localparam int MAX_DIM     = BUS_WIDTH / DATA_WIDTH;
   localparam int SP_NTARGETS = 4;
   localparam int DIM_W       = $clog2(MAX_DIM) + 1;
   localparam int SPA_W       = $clog2(SP_NTARGETS * MAX_DIM);
   localparam int CALC_CNT_W  = $clog2(3 * MAX_DIM);

`ifdef MATMUL_BIAS_EN
   typedef enum logic [2:0] {IDLE, LOAD, BIAS, CALC, WRITE, DONE} ctrl_state_e;
`else
   typedef enum logic [2:0] {IDLE, LOAD, CALC, WRITE, DONE} ctrl_state_e;
`endif

   function automatic logic dim_ok(input int d, input int max_dim);
      return (d >= 1) && (d <= max_dim);
   endfunction
endpackage

// File: rtl/matmul_sp_port.sv
// Scratchpad row port shared by the bias-read and result-write phases.
// Optional feature macro: MATMUL_BIAS_EN (enables the accumulator-load strobe).
module matmul_sp_port #(
   parameter int MAX_DIM     = matmul_pkg::MAX_DIM,
   parameter int SP_NTARGETS = matmul_pkg::SP_NTARGETS,
   localparam int DIM_W      = $clog2(MAX_DIM) + 1,
   localparam int ROW_W      = DIM_W - 1,
   localparam int TGT_W      = $clog2(SP_NTARGETS),
   localparam int SPA_W      = $clog2(SP_NTARGETS * MAX_DIM)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rd_phase,
   input  logic             wr_phase,
   input  logic [DIM_W-1:0] n_dim,
   input  logic [TGT_W-1:0] target,
   input  logic             gnt,
   output logic             req,
   output logic             we,
   output logic [SPA_W-1:0] addr,
   output logic             last_gnt,
   output logic             acc_ld,
   output logic [ROW_W-1:0] acc_row
);
   import matmul_pkg::*;

   logic [ROW_W-1:0] row_q;
   logic             active;
   logic             granted;

   assign active   = rd_phase | wr_phase;
   assign granted  = active & gnt;
   assign last_gnt = granted && ({1'b0, row_q} == (n_dim - DIM_W'(1)));
   assign req      = active;
   assign we       = wr_phase;
   assign addr     = SPA_W'(target) * SPA_W'(MAX_DIM) + SPA_W'(row_q);

   // Row only moves on a grant, which keeps req/we/addr frozen through a stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q <= '0;
      end else if (!active || last_gnt) begin
         row_q <= '0;
      end else if (granted) begin
         row_q <= row_q + ROW_W'(1);
      end
   end

`ifdef MATMUL_BIAS_EN
   // Read data arrives one cycle after the grant, so the load strobe is delayed to match.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_ld  <= 1'b0;
         acc_row <= '0;
      end else begin
         acc_ld  <= rd_phase & gnt;
         acc_row <= (rd_phase & gnt) ? row_q : '0;
      end
   end
`else
   assign acc_ld  = 1'b0;
   assign acc_row = '0;
`endif
endmodule

// File: rtl/matmul_ctrl.sv
// Sequencer FSM for the matmul engine: load, optional bias preload, compute, write-back.
// Optional feature macro: MATMUL_BIAS_EN (BIAS state and accumulator preload).
module matmul_ctrl #(
   parameter int DATA_WIDTH  = matmul_pkg::DATA_WIDTH,
   parameter int BUS_WIDTH   = matmul_pkg::BUS_WIDTH,
   parameter int MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
   parameter int SP_NTARGETS = matmul_pkg::SP_NTARGETS,
   localparam int DIM_W      = $clog2(MAX_DIM) + 1,
   localparam int SPA_W      = $clog2(SP_NTARGETS * MAX_DIM),
   localparam int TGT_W      = $clog2(SP_NTARGETS),
   localparam int CALC_CNT_W = $clog2(3 * MAX_DIM)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic [DIM_W-1:0] n_dim_i,
   input  logic [DIM_W-1:0] k_dim_i,
   input  logic [DIM_W-1:0] m_dim_i,
   input  logic [TGT_W-1:0] target_i,
   input  logic             bias_i,
   output logic             load_o,
   output logic             clr_acc_o,
   output logic             calc_en_o,
   output logic             acc_ld_o,
   output logic [DIM_W-2:0] acc_row_o,
   output logic             sp_req_o,
   output logic             sp_we_o,
   output logic [SPA_W-1:0] sp_addr_o,
   input  logic             sp_gnt_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o
);
   import matmul_pkg::*;

   ctrl_state_e           state_q, state_d;
   logic [DIM_W-1:0]      n_q, k_q, m_q;
   logic [TGT_W-1:0]      target_q;
   logic [CALC_CNT_W-1:0] calc_cnt_q;
   logic [CALC_CNT_W-1:0] calc_len;
   logic                  err_q;
   logic                  dims_ok;
   logic                  last_gnt;
   logic                  rd_phase;
   logic                  wr_phase;
`ifdef MATMUL_BIAS_EN
   logic                  bias_q;
`else
   logic                  unused_bias;
   assign unused_bias = bias_i;
`endif

   assign dims_ok  = dim_ok(int'(n_dim_i), MAX_DIM) && dim_ok(int'(k_dim_i), MAX_DIM)
                     && dim_ok(int'(m_dim_i), MAX_DIM);
   assign calc_len = CALC_CNT_W'(k_q) + CALC_CNT_W'(n_q) + CALC_CNT_W'(m_q)
                     - CALC_CNT_W'(2);
   assign err_o    = err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Job parameters are captured only on an accepted start; the error flag lives until then.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         n_q        <= '0;
         k_q        <= '0;
         m_q        <= '0;
         target_q   <= '0;
         err_q      <= 1'b0;
         calc_cnt_q <= '0;
`ifdef MATMUL_BIAS_EN
         bias_q     <= 1'b0;
`endif
      end else begin
         if (state_q == IDLE && start_i) begin
            n_q      <= n_dim_i;
            k_q      <= k_dim_i;
            m_q      <= m_dim_i;
            target_q <= target_i;
            err_q    <= !dims_ok;
`ifdef MATMUL_BIAS_EN
            bias_q   <= bias_i;
`endif
         end
         if (state_q == LOAD) begin
            calc_cnt_q <= calc_len;
         end else if (state_q == CALC && calc_cnt_q != '0) begin
            calc_cnt_q <= calc_cnt_q - CALC_CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      load_o    = 1'b0;
      clr_acc_o = 1'b0;
      calc_en_o = 1'b0;
      rd_phase  = 1'b0;
      wr_phase  = 1'b0;
      busy_o    = 1'b1;
      done_o    = 1'b0;
      case (state_q)
         IDLE: begin
            busy_o = 1'b0;
            if (start_i) begin
               state_d = dims_ok ? LOAD : DONE;
            end
         end
`ifdef MATMUL_BIAS_EN
         LOAD: begin
            load_o    = 1'b1;
            clr_acc_o = !bias_q;
            state_d   = bias_q ? BIAS : CALC;
         end
         BIAS: begin
            rd_phase = 1'b1;
            if (last_gnt) begin
               state_d = CALC;
            end
         end
`else
         LOAD: begin
            load_o    = 1'b1;
            clr_acc_o = 1'b1;
            state_d   = CALC;
         end
`endif
         CALC: begin
            calc_en_o = 1'b1;
            if (calc_cnt_q <= CALC_CNT_W'(1)) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            wr_phase = 1'b1;
            if (last_gnt) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            busy_o  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   matmul_sp_port #(
      .MAX_DIM     (MAX_DIM),
      .SP_NTARGETS (SP_NTARGETS)
   ) u_sp_port (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .rd_phase (rd_phase),
      .wr_phase (wr_phase),
      .n_dim    (n_q),
      .target   (target_q),
      .gnt      (sp_gnt_i),
      .req      (sp_req_o),
      .we       (sp_we_o),
      .addr     (sp_addr_o),
      .last_gnt (last_gnt),
      .acc_ld   (acc_ld_o),
      .acc_row  (acc_row_o)
   );
endmodule

// File: tb/tb_matmul_ctrl.sv
// Self-checking bench for matmul_ctrl: directed job table, random jobs scored against
// a cycle-count model of the job timeline, and hand-written reset/restart sequences.
`timescale 1ns/1ps
module tb_matmul_ctrl;
   import matmul_pkg::*;

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b0;
   logic             start_i = 1'b0;
   logic [DIM_W-1:0] n_dim_i = '0;
   logic [DIM_W-1:0] k_dim_i = '0;
   logic [DIM_W-1:0] m_dim_i = '0;
   logic [1:0]       target_i = '0;
   logic             bias_i = 1'b0;
   logic             sp_gnt_i = 1'b0;
   logic             load_o, clr_acc_o, calc_en_o, acc_ld_o;
   logic [DIM_W-2:0] acc_row_o;
   logic             sp_req_o, sp_we_o;
   logic [SPA_W-1:0] sp_addr_o;
   logic             busy_o, done_o, err_o;

   matmul_ctrl dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .start_i   (start_i),
      .n_dim_i   (n_dim_i),
      .k_dim_i   (k_dim_i),
      .m_dim_i   (m_dim_i),
      .target_i  (target_i),
      .bias_i    (bias_i),
      .load_o    (load_o),
      .clr_acc_o (clr_acc_o),
      .calc_en_o (calc_en_o),
      .acc_ld_o  (acc_ld_o),
      .acc_row_o (acc_row_o),
      .sp_req_o  (sp_req_o),
      .sp_we_o   (sp_we_o),
      .sp_addr_o (sp_addr_o),
      .sp_gnt_i  (sp_gnt_i),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .err_o     (err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int n, k, m, tgt, s0, s1;
      int exp_calc, exp_busy, exp_err;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int stall_tab[8];

   int obs_load, obs_clr, obs_calc, obs_calc_first, obs_calc_last, obs_busy;
   int obs_done, obs_done_idx, obs_req_cycles, obs_hold_viol;
   int obs_err_first, obs_err_after, obs_idle_busy, obs_timeout;
   int obs_wr_addr[$];
   int obs_rd_addr[$];
   int obs_acc_row[$];
   int obs_acc_idx[$];

   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Runs one job: drives start, serves grants per stall_tab, records what the DUT did.
   task automatic applyStimulus(input int n, input int k, input int m, input int tgt,
                                input int bias, input int restart_at);
      int  gidx, stall_left;
      bit  prev_req, prev_we, prev_gnt, seen_done;
      int  prev_addr;
      obs_load = 0; obs_clr = 0; obs_calc = 0; obs_calc_first = -1; obs_calc_last = -1;
      obs_busy = 0; obs_done = 0; obs_done_idx = -1; obs_req_cycles = 0;
      obs_hold_viol = 0; obs_err_first = -1; obs_err_after = -1; obs_idle_busy = -1;
      obs_timeout = 0;
      obs_wr_addr.delete(); obs_rd_addr.delete();
      obs_acc_row.delete(); obs_acc_idx.delete();
      @(negedge clk_i);
      n_dim_i  = DIM_W'(n);
      k_dim_i  = DIM_W'(k);
      m_dim_i  = DIM_W'(m);
      target_i = 2'(tgt);
      bias_i   = (bias != 0);
      start_i  = 1'b1;
      @(negedge clk_i);
      start_i    = 1'b0;
      gidx       = 0;
      stall_left = stall_tab[0];
      prev_req   = 1'b0; prev_we = 1'b0; prev_gnt = 1'b0; prev_addr = 0;
      seen_done  = 1'b0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         sp_gnt_i = 1'b0;
         start_i  = 1'b0;
         if (cyc == 0) obs_err_first = int'(err_o);
         if (load_o) obs_load++;
         if (clr_acc_o) obs_clr++;
         if (busy_o) obs_busy++;
         if (calc_en_o) begin
            if (obs_calc_first < 0) obs_calc_first = cyc;
            obs_calc_last = cyc;
            obs_calc++;
         end
         if (prev_req && !prev_gnt) begin
            if (!sp_req_o || sp_we_o != prev_we || int'(sp_addr_o) != prev_addr)
               obs_hold_viol++;
         end
         if (sp_req_o) begin
            obs_req_cycles++;
            if (stall_left > 0) begin
               stall_left--;
            end else begin
               sp_gnt_i = 1'b1;
               if (sp_we_o) obs_wr_addr.push_back(int'(sp_addr_o));
               else obs_rd_addr.push_back(int'(sp_addr_o));
               gidx++;
               stall_left = stall_tab[gidx % 8];
            end
         end
         if (acc_ld_o) begin
            obs_acc_row.push_back(int'(acc_row_o));
            obs_acc_idx.push_back(cyc);
         end
         if (restart_at >= 0 && cyc == restart_at) begin
            n_dim_i  = DIM_W'(1);
            k_dim_i  = DIM_W'(1);
            m_dim_i  = DIM_W'(1);
            target_i = 2'(tgt + 1);
            start_i  = 1'b1;
         end
         prev_req  = sp_req_o;
         prev_we   = sp_we_o;
         prev_addr = int'(sp_addr_o);
         prev_gnt  = sp_gnt_i;
         if (done_o) begin
            obs_done++;
            obs_done_idx = cyc;
            seen_done    = 1'b1;
         end
         @(negedge clk_i);
         if (seen_done) break;
      end
      sp_gnt_i = 1'b0;
      start_i  = 1'b0;
      if (!seen_done) begin
         obs_timeout = 1;
      end else begin
         obs_idle_busy = int'(busy_o);
         obs_err_after = int'(err_o);
      end
   endtask

   // Expected job timeline from the rules: 1 LOAD, reads, K+N+M-2 compute, writes, DONE.
   task automatic verifyJob(input string tag, input int n, input int k, input int m,
                            input int tgt, input int bias);
      bit legal;
      int eb, reads, rd_cyc, wr_cyc, calc, done_idx, gcyc;
      legal = (n >= 1 && n <= MAX_DIM) && (k >= 1 && k <= MAX_DIM)
              && (m >= 1 && m <= MAX_DIM);
`ifdef MATMUL_BIAS_EN
      eb = bias;
`else
      eb = 0;
`endif
      checkOutput({tag, "/timeout"}, obs_timeout, 0);
      checkOutput({tag, "/done_cnt"}, obs_done, 1);
      checkOutput({tag, "/idle_busy"}, obs_idle_busy, 0);
      if (!legal) begin
         checkOutput({tag, "/err_done_idx"}, obs_done_idx, 0);
         checkOutput({tag, "/err_flag"}, obs_err_first, 1);
         checkOutput({tag, "/err_held"}, obs_err_after, 1);
         checkOutput({tag, "/err_load"}, obs_load, 0);
         checkOutput({tag, "/err_calc"}, obs_calc, 0);
         checkOutput({tag, "/err_req"}, obs_req_cycles, 0);
         checkOutput({tag, "/err_busy"}, obs_busy, 1);
         return;
      end
      reads  = (eb != 0) ? n : 0;
      rd_cyc = 0;
      for (int i = 0; i < reads; i++) rd_cyc += stall_tab[i] + 1;
      wr_cyc = 0;
      for (int i = 0; i < n; i++) wr_cyc += stall_tab[reads + i] + 1;
      calc     = k + n + m - 2;
      done_idx = 1 + rd_cyc + calc + wr_cyc;
      checkOutput({tag, "/done_idx"}, obs_done_idx, done_idx);
      checkOutput({tag, "/busy"}, obs_busy, done_idx + 1);
      checkOutput({tag, "/load"}, obs_load, 1);
      checkOutput({tag, "/clr"}, obs_clr, 1 - eb);
      checkOutput({tag, "/calc"}, obs_calc, calc);
      checkOutput({tag, "/calc_first"}, obs_calc_first, 1 + rd_cyc);
      checkOutput({tag, "/calc_last"}, obs_calc_last, rd_cyc + calc);
      checkOutput({tag, "/req_cycles"}, obs_req_cycles, rd_cyc + wr_cyc);
      checkOutput({tag, "/hold"}, obs_hold_viol, 0);
      checkOutput({tag, "/err_flag"}, obs_err_first, 0);
      checkOutput({tag, "/err_held"}, obs_err_after, 0);
      checkOutput({tag, "/wr_count"}, obs_wr_addr.size(), n);
      for (int i = 0; i < n; i++)
         checkOutput({tag, "/wr_addr"}, (i < obs_wr_addr.size()) ? obs_wr_addr[i] : -1,
                     tgt * MAX_DIM + i);
      checkOutput({tag, "/rd_count"}, obs_rd_addr.size(), reads);
      checkOutput({tag, "/acc_count"}, obs_acc_row.size(), reads);
      gcyc = 1;
      for (int i = 0; i < reads; i++) begin
         gcyc += stall_tab[i];
         checkOutput({tag, "/rd_addr"}, (i < obs_rd_addr.size()) ? obs_rd_addr[i] : -1,
                     tgt * MAX_DIM + i);
         checkOutput({tag, "/acc_row"}, (i < obs_acc_row.size()) ? obs_acc_row[i] : -1, i);
         checkOutput({tag, "/acc_idx"}, (i < obs_acc_idx.size()) ? obs_acc_idx[i] : -1,
                     gcyc + 1);
         gcyc += 1;
      end
   endtask

   initial begin
      vec_t vecs[7];
      int   n, k, m, tgt, bias;
      bit   found, saw_done;
      vecs[0] = '{2, 2, 2, 1, 0, 0, 4, 8, 0};
      vecs[1] = '{1, 2, 1, 3, 5, 0, 2, 10, 0};
      vecs[2] = '{2, 0, 2, 0, 0, 0, 0, 1, 1};
      vecs[3] = '{3, 0, 1, 2, 0, 0, 0, 1, 1};
      vecs[4] = '{1, 1, 1, 0, 0, 0, 1, 4, 0};
      vecs[5] = '{2, 1, 2, 2, 0, 3, 3, 10, 0};
      vecs[6] = '{1, 1, 0, 1, 0, 0, 0, 1, 1};
      for (int i = 0; i < 8; i++) stall_tab[i] = 0;

      rst_ni = 1'b0;
      repeat (2) @(negedge clk_i);
      checkOutput("reset/load", int'(load_o), 0);
      checkOutput("reset/clr", int'(clr_acc_o), 0);
      checkOutput("reset/calc", int'(calc_en_o), 0);
      checkOutput("reset/acc_ld", int'(acc_ld_o), 0);
      checkOutput("reset/acc_row", int'(acc_row_o), 0);
      checkOutput("reset/req", int'(sp_req_o), 0);
      checkOutput("reset/we", int'(sp_we_o), 0);
      checkOutput("reset/addr", int'(sp_addr_o), 0);
      checkOutput("reset/busy", int'(busy_o), 0);
      checkOutput("reset/done", int'(done_o), 0);
      checkOutput("reset/err", int'(err_o), 0);
      rst_ni = 1'b1;

      for (int v = 0; v < 7; v++) begin
         for (int i = 0; i < 8; i++) stall_tab[i] = 0;
         stall_tab[0] = vecs[v].s0;
         stall_tab[1] = vecs[v].s1;
         applyStimulus(vecs[v].n, vecs[v].k, vecs[v].m, vecs[v].tgt, 0, -1);
         checkOutput($sformatf("vec%0d/calc", v), obs_calc, vecs[v].exp_calc);
         checkOutput($sformatf("vec%0d/busy", v), obs_busy, vecs[v].exp_busy);
         checkOutput($sformatf("vec%0d/err", v), obs_err_first, vecs[v].exp_err);
         verifyJob($sformatf("vec%0d", v), vecs[v].n, vecs[v].k, vecs[v].m,
                   vecs[v].tgt, 0);
      end

      for (int i = 0; i < 8; i++) stall_tab[i] = 0;
      applyStimulus(2, 2, 2, 1, 0, 2);
      verifyJob("restart", 2, 2, 2, 1, 0);

`ifdef MATMUL_BIAS_EN
      applyStimulus(2, 2, 2, 0, 1, -1);
      verifyJob("bias", 2, 2, 2, 0, 1);
      stall_tab[0] = 2;
      applyStimulus(2, 1, 1, 3, 1, -1);
      verifyJob("bias_stall", 2, 1, 1, 3, 1);
      stall_tab[0] = 0;
`endif

      @(negedge clk_i);
      n_dim_i = DIM_W'(2); k_dim_i = DIM_W'(1); m_dim_i = DIM_W'(1);
      target_i = 2'(2); bias_i = 1'b0; start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      found   = 1'b0;
      for (int c = 0; c < 50 && !found; c++) begin
         sp_gnt_i = 1'b0;
         if (sp_req_o && sp_we_o && int'(sp_addr_o) == 5) begin
            found = 1'b1;
         end else begin
            if (sp_req_o) sp_gnt_i = 1'b1;
            @(negedge clk_i);
         end
      end
      sp_gnt_i = 1'b0;
      checkOutput("rst_mid/reached_row1", int'(found), 1);
      rst_ni = 1'b0;
      #1;
      checkOutput("rst_mid/req", int'(sp_req_o), 0);
      checkOutput("rst_mid/we", int'(sp_we_o), 0);
      checkOutput("rst_mid/addr", int'(sp_addr_o), 0);
      checkOutput("rst_mid/busy", int'(busy_o), 0);
      checkOutput("rst_mid/calc", int'(calc_en_o), 0);
      saw_done = 1'b0;
      repeat (3) begin
         @(posedge clk_i);
         #1;
         if (done_o || busy_o) saw_done = 1'b1;
      end
      checkOutput("rst_mid/no_done", int'(saw_done), 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      applyStimulus(2, 2, 1, 3, 0, -1);
      verifyJob("after_rst", 2, 2, 1, 3, 0);

      for (int r = 0; r < 25; r++) begin
         if ($urandom_range(0, 9) < 8) begin
            n = $urandom_range(1, MAX_DIM);
            k = $urandom_range(1, MAX_DIM);
            m = $urandom_range(1, MAX_DIM);
         end else begin
            n = $urandom_range(0, 3);
            k = $urandom_range(0, 3);
            m = $urandom_range(0, 3);
         end
         tgt  = $urandom_range(0, 3);
         bias = $urandom_range(0, 1);
         for (int i = 0; i < 8; i++) stall_tab[i] = $urandom_range(0, 3);
         applyStimulus(n, k, m, tgt, bias, -1);
         verifyJob($sformatf("rand%0d", r), n, k, m, tgt, bias);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule

// File: doc/matmul_ctrl.md
# matmul_ctrl

Sequencer FSM for the matmul engine. It accepts a start pulse with operand dimensions and a scratchpad target, drives the systolic datapath through load, clear, compute and drain, then writes result rows into the shared scratchpad through a request/grant port. It sits between the APB register file (start, dims, target, status) and the calc datapath plus scratchpad arbiter.

## Interface
Parameters (defaults from `matmul_pkg`):
- `DATA_WIDTH`, 16, element width (passes to package types only)
- `BUS_WIDTH`, 32, bus width
- `MAX_DIM`, `BUS_WIDTH/DATA_WIDTH` = 2, max N/K/M
- `SP_NTARGETS`, 4, scratchpad result slots

Ports (`DIM_W = $clog2(MAX_DIM)+1`; `SPA_W = $clog2(SP_NTARGETS*MAX_DIM)`):
- `clk_i` in 1: single clock
- `rst_ni` in 1: asynchronous, active-low reset
- `start_i` in 1: start pulse from control register
- `n_dim_i`, `k_dim_i`, `m_dim_i` in DIM_W each: dimensions; legal range 1..MAX_DIM
- `target_i` in `$clog2(SP_NTARGETS)`: destination slot
- `bias_i` in 1: accumulate onto the existing slot contents (needs `MATMUL_BIAS_EN`)
- `load_o` out 1: operand capture pulse
- `clr_acc_o` out 1: accumulator clear pulse
- `calc_en_o` out 1: systolic step enable
- `acc_ld_o` out 1: load accumulator row `acc_row_o` from `sp_rdata`
- `acc_row_o` out DIM_W-1: accumulator row index
- `sp_req_o`, `sp_we_o` out 1: scratchpad request / write
- `sp_addr_o` out SPA_W: `target*MAX_DIM + row`
- `sp_gnt_i` in 1: arbiter grant
- `busy_o`, `done_o`, `err_o` out 1: status

## Operation
- States: IDLE, LOAD, BIAS, CALC, WRITE, DONE.
- IDLE:
  - On `start_i`, latch dims, target and bias.
  - If any dim is 0 or greater than MAX_DIM, go to DONE with `err_o`=1. No datapath strobes are issued.
  - Otherwise go to LOAD.
- LOAD (1 cycle):
  - Assert `load_o`.
  - Assert `clr_acc_o` unless bias is set.
  - Next state is BIAS if bias is set, else CALC.
- BIAS: read rows 0..N-1, one per grant (`sp_req_o`=1, `sp_we_o`=0). Then go to CALC.
- CALC:
  - Assert `calc_en_o` for exactly `K+N+M-2` cycles, counted by a down-counter.
  - Counter width is `$clog2(3*MAX_DIM)`; it never wraps.
- WRITE: write rows 0..N-1 (`sp_req_o`=1, `sp_we_o`=1). The row advances only on `sp_req_o && sp_gnt_i`. After row N-1 is granted, go to DONE.
- DONE (1 cycle): pulse `done_o`, then return to IDLE.
- `err_o` is held from DONE until the next accepted start.
- `start_i` while not IDLE is ignored and does not disturb the current job.

## Timing
- Reset values: every output is 0; state is IDLE; row and cycle counters are 0.
- Reset mid-job aborts immediately. No write completes after `rst_ni` falls.
- `busy_o`=1 from the cycle after `start_i` is sampled through DONE inclusive.
- Request hold rule: `sp_req_o`, `sp_we_o` and `sp_addr_o` stay stable while `sp_req_o && !sp_gnt_i`. Grant may stall indefinitely.
- Grant on the last row: `sp_req_o` drops in the following cycle.
- Bias read data is valid the cycle after grant. `acc_ld_o` pulses that cycle, with `acc_row_o` = the granted row.
- `acc_ld_o` for the last row overlaps the first CALC cycle.
- Legal job, zero-wait grants: start(t0) → LOAD t1 → CALC t2..t1+(K+N+M-2) → N WRITE cycles → DONE.
- Error job: start(t0) → DONE t1 (`done_o`, `err_o`=1) → IDLE t2.

## Configuration
- `MATMUL_BIAS_EN` defined: the BIAS state and `acc_ld_o` are implemented.
- Undefined:
  - `bias_i` is ignored and LOAD always asserts `clr_acc_o`.
  - `acc_ld_o` and `acc_row_o` are tied 0.
  - BIAS is removed from the state enum.

## Structure
- `matmul_pkg` holds:
  - `typedef enum logic [2:0] ctrl_state_e` {IDLE, LOAD, BIAS, CALC, WRITE, DONE}
  - `localparam DIM_W`
  - `localparam SPA_W`
  - `localparam CALC_CNT_W`
- One sub-module, `matmul_sp_port`:
  - Owns the row counter, address generation, request/grant hold, and the read-data-valid delay.
  - Shared by the BIAS and WRITE phases.

## Test plan
- N=K=M=2, target 1, zero-wait grant → `calc_en_o` high 4 cycles; writes to addr 2, 3; `done_o` 1 pulse; `busy_o` high 8 cycles.
- N=1, K=2, M=1, target 3, grant withheld 5 cycles on row 0 → `sp_addr_o`=6 stable 6 cycles; single write; `calc_en_o` 2 cycles.
- k_dim=0 (also repeated with n_dim=3) → `done_o` and `err_o` the cycle after start; no `load_o`/`calc_en_o`/`sp_req_o`; `err_o` clears on the next legal start.
- `start_i` reasserted during CALC → ignored; exact original cycle count and addresses.
- `rst_ni` low during WRITE row 1 → all outputs 0 at once; no `done_o`; a fresh job afterwards completes normally.
- `MATMUL_BIAS_EN`, `bias_i`=1, N=2, target 0 → no `clr_acc_o`; reads addr 0, 1; `acc_ld_o` one cycle after each grant with row 0, 1; then CALC.
